// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: instruction format, op codes,
// ALU opcode values and the control-unit state encoding.
package cpu_pkg;

    // Instruction word layout: [11:8] op, [7:0] immediate
    localparam int unsigned INSTR_W = 12;
    localparam int unsigned OP_MSB  = 11;
    localparam int unsigned OP_LSB  = 8;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    // Instruction op codes; 0x0-0xA map one-to-one onto ALU opcodes
    localparam logic [3:0] OP_INC = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_DEC = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_IOR = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_INV = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_MOV = 4'hA;
    localparam logic [3:0] OP_LDI = 4'hB;
    localparam logic [3:0] OP_CLE = 4'hC;
    localparam logic [3:0] OP_CME = 4'hD;
    localparam logic [3:0] OP_NOP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ALU opcode values, shared with the ALU
    localparam logic [3:0] ALU_INC = 4'h0;
    localparam logic [3:0] ALU_ADD = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_DEC = 4'h3;
    localparam logic [3:0] ALU_AND = 4'h4;
    localparam logic [3:0] ALU_IOR = 4'h5;
    localparam logic [3:0] ALU_XOR = 4'h6;
    localparam logic [3:0] ALU_INV = 4'h7;
    localparam logic [3:0] ALU_SHR = 4'h8;
    localparam logic [3:0] ALU_SHL = 4'h9;
    localparam logic [3:0] ALU_MOV = 4'hA;

    // Control-unit states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/acc_ctrl.sv
// Accumulator control unit: fetches 12-bit instructions over a req/ack
// port, drives the external combinational ALU and captures its result
// into AC/E; LDI, E manipulation, NOP and HLT are executed locally.
module acc_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 instr_req,
    output logic [PC_W-1:0]      instr_addr,
    input  logic                 instr_ack,
    input  logic [INSTR_W-1:0]   instr_data,
    output logic [3:0]           alu_opcode,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic                 alu_e,
    input  logic [7:0]           alu_res,
    input  logic                 alu_e_res,
    output logic [7:0]           ac,
    output logic                 e,
    output logic                 busy,
    output logic                 halted
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [7:0]          ac_q, ac_d;
    logic                e_q, e_d;
    logic [3:0]          op;

    assign op = ir_q[OP_MSB:OP_LSB];

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= START_PC;
            ir_q    <= '0;
            ac_q    <= '0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ac_q    <= ac_d;
            e_q     <= e_d;
        end
    end

    // Next-state, fetch/decode/execute and ALU opcode selection
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ac_d       = ac_q;
        e_d        = e_q;
        alu_opcode = ALU_MOV;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (instr_ack) begin
                    ir_d    = instr_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (op <= OP_MOV) begin
                    alu_opcode = op;
                    ac_d       = alu_res;
                    e_d        = alu_e_res;
                end else begin
                    unique case (op)
                        OP_LDI:  ac_d = ir_q[IMM_MSB:IMM_LSB];
                        OP_CLE:  e_d  = 1'b0;
                        OP_CME:  e_d  = ~e_q;
                        OP_HLT:  state_d = ST_HALT;
                        default: ;
                    endcase
                end
            end
            ST_HALT: begin
                if (start) state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign instr_req  = (state_q == ST_FETCH);
    assign instr_addr = pc_q;
    assign alu_a      = ac_q;
    assign alu_b      = ir_q[IMM_MSB:IMM_LSB];
    assign alu_e      = e_q;
    assign ac         = ac_q;
    assign e          = e_q;
    assign busy       = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign halted     = (state_q == ST_HALT);

endmodule

// File: doc/acc_ctrl.md
Name: acc_ctrl

Overview:
- Accumulator control unit for the 8-bit CPU datapath; the stage directly upstream of the ALU.
- Fetches 12-bit instructions over a req/ack port and decodes them.
- Drives the ALU inputs: opcode, a = AC, b = immediate, E.
- Captures the ALU result and carry back into the AC and E registers.
- Also executes the non-ALU instructions itself: load-immediate, E manipulation and halt.

Parameters:
- PC_W, 8, program counter / instruction address width.
- START_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins or resumes execution.
- instr_req  out  1  instruction fetch request.
- instr_addr  out  PC_W  fetch address; equals pc.
- instr_ack  in  1  fetch complete; instr_data is valid this cycle.
- instr_data  in  12  instruction: [11:8] op, [7:0] imm.
- alu_opcode  out  4  to ALU opcode.
- alu_a  out  8  to ALU a; always equals ac.
- alu_b  out  8  to ALU b; equals ir[7:0].
- alu_e  out  1  to ALU E; always equals e.
- alu_res  in  8  from ALU result.
- alu_e_res  in  1  from ALU E_out.
- ac  out  8  accumulator.
- e  out  1  extend/carry bit.
- busy  out  1  high in FETCH or EXEC.
- halted  out  1  high in HALT.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, pc=START_PC, ir=0, ac=0, e=0, instr_req=0, busy=0, halted=0.
- Reset mid-fetch or mid-exec aborts immediately; any late instr_ack is ignored.
- States:
  - IDLE: start -> FETCH.
  - FETCH: instr_req=1, instr_addr=pc, held stable until instr_ack. On ack: ir<=instr_data, pc<=pc+1 (wraps 2^PC_W-1 -> 0), -> EXEC.
  - EXEC: exactly one cycle, then -> FETCH; HLT -> HALT instead.
  - HALT: start -> FETCH, resuming at the current pc. All other inputs are ignored.
- start is ignored in FETCH and EXEC.
- instr_ack outside FETCH is ignored.
- instr_req deasserts in the cycle after ack; it is combinational from state.
- Instruction op codes:
  - 0x0-0xA: ALU ops (INC, ADD, SUB, DEC, AND, IOR, XOR, INV, SHR, SHL, MOV). In EXEC, alu_opcode=ir[11:8]; at the EXEC edge, ac<=alu_res and e<=alu_e_res.
  - 0xB LDI: ac<=ir[7:0]; e unchanged.
  - 0xC CLE: e<=0; ac unchanged.
  - 0xD CME: e<=~e; ac unchanged.
  - 0xE NOP: no register change.
  - 0xF HLT: no register change; -> HALT, halted=1 from the next cycle.
- Outside EXEC, and in EXEC for ops 0xB-0xF: alu_opcode=4'hA (MOV), so the ALU output stays defined. The block never presents opcodes 0xB-0xF to the ALU.
- Timing: with instr_ack in the same cycle as the request, throughput is 2 cycles per instruction. Each wait cycle adds one.
- The ALU is combinational, so the result is captured on the same EXEC edge; there is no writeback state.

Decomposition:
- Shared package cpu_pkg holds:
  - Instruction op constants (OP_INC..OP_MOV, OP_LDI, OP_CLE, OP_CME, OP_NOP, OP_HLT).
  - The instruction field positions.
  - The state encoding: IDLE, FETCH, EXEC, HALT.
  - The ALU opcode values, which are shared with the ALU.
- No sub-module: the PC counter and decode are small enough to stay inline.
- The ALU is instantiated beside this block at the next level up, not inside it.

Test Plan:
- Reset release then start=1, program {B05, 000}, ack same cycle -> ac=0x05 after 2 cycles, ac=0x06 after 4 cycles, e=0, pc=2.
- LDI 0xF0, then 0x10F (ADD 0x0F), then 0x101 (ADD 0x01) -> ac=0xFF with e=0, then ac=0x00 with e=1.
- e=1, ac=0x81, op 8 (SHR) -> ac=0xC0, e=1.
- Op D (CME) -> e=0. Op 9 (SHL) on ac=0x81 -> ac=0x02, e=1.
- instr_ack delayed 3 cycles -> instr_req and instr_addr held constant throughout; exactly one instruction is executed; start pulses during the wait have no effect.
- Program {B07, F00, 000}:
  - halted=1, ac=0x07, pc=2, instr_req=0 for 10 cycles.
  - start -> fetch at addr 2; ac=0x08.
  - rst asserted during FETCH -> next cycle all outputs at reset values.
- PC wrap with PC_W=8: execute 256 NOPs -> instr_addr returns to 0x00.
